repair_fault_map: RTL and testbench

Records faulty main-memory segments reported by BIST during a test run and answers per-access remap lookups for the memory controller in normal mode. It sits between the BIST engine (fault producer) and the controller's normal-mode path, reading the BIST fault log and turning it into spare-bank selects and addresses. One entry maps one 128-word segment of one main bank (key = {bank select, word address[9:7]}) onto one of 25 spare banks.

---
 rtl/repair_fault_map.sv | 142 ++++++++++++++
 tb/tb_repair_fault_map.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/repair_fault_map.sv
// Captures BIST fault segments into a 25-entry spare map and answers remap lookups.
// Lookup latency 1 cycle, one lookup accepted every cycle (no backpressure); capture visible next cycle.
module repair_fault_map #(
  parameter int ENTRIES      = 25,
  parameter int SEL_W        = 6,
  parameter int ADDR_W       = 10,
  parameter int SPARE_SEL_W  = 5,
  parameter int SPARE_ADDR_W = 7
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    BIST_EN,
  input  logic                    FAULT_VALID,
  input  logic [SEL_W-1:0]        FAULT_SEL,
  input  logic [ADDR_W-1:0]       FAULT_ADDR,
  input  logic                    LK_VALID,
  input  logic [15:0]             LK_ADDR,
  output logic                    LK_DONE,
  output logic                    LK_HIT,
  output logic [SPARE_SEL_W-1:0]  LK_SPARE_SEL,
  output logic [SPARE_ADDR_W-1:0] LK_SPARE_ADDR,
  output logic [4:0]              FAULT_CNT,
  output logic                    OVERFLOW,
  output logic                    MAP_READY
);

  localparam int KEY_W = SEL_W + ADDR_W - SPARE_ADDR_W;
  localparam logic [4:0] ENTRIES_C = 5'(ENTRIES);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_CAPTURE = 2'd1,
    S_SEALED  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ENTRIES-1:0] valid_q;
  logic [KEY_W-1:0]   key_q [ENTRIES];

  logic [KEY_W-1:0]       fault_key;
  logic [KEY_W-1:0]       lk_key;
  logic                   clear_tbl;
  logic                   cap_fire;
  logic                   dup;
  logic                   store;
  logic                   lk_match;
  logic [SPARE_SEL_W-1:0] lk_idx;

  assign fault_key = {FAULT_SEL, FAULT_ADDR[ADDR_W-1:SPARE_ADDR_W]};
  assign lk_key    = LK_ADDR[SEL_W+ADDR_W-1:SPARE_ADDR_W];
  assign MAP_READY = (state == S_SEALED);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear_tbl = 1'b0;
    case (state)
      S_EMPTY: if (BIST_EN) begin
        state_nxt = S_CAPTURE;
        clear_tbl = 1'b1;
      end
      S_CAPTURE: if (!BIST_EN) state_nxt = S_SEALED;
      S_SEALED: if (BIST_EN) begin
        state_nxt = S_CAPTURE;
        clear_tbl = 1'b1;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // A report arriving on the cycle BIST_EN drops is ignored, as is one in EMPTY/SEALED.
  assign cap_fire = (state == S_CAPTURE) && BIST_EN && FAULT_VALID;

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (key_q[i] == fault_key)) dup = 1'b1;
    end
  end

  assign store = cap_fire && !dup && (FAULT_CNT < ENTRIES_C);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q   <= '0;
      FAULT_CNT <= '0;
      OVERFLOW  <= 1'b0;
    end else if (clear_tbl) begin
      valid_q   <= '0;
      FAULT_CNT <= '0;
      OVERFLOW  <= 1'b0;
    end else if (store) begin
      valid_q[FAULT_CNT] <= 1'b1;
      FAULT_CNT          <= FAULT_CNT + 5'd1;
    end else if (cap_fire && !dup) begin
      OVERFLOW <= 1'b1;
    end
  end

  // Keys are qualified by valid_q, so they need no reset.
  always_ff @(posedge CLK) begin
    if (store) key_q[FAULT_CNT] <= fault_key;
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    lk_match = 1'b0;
    lk_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == lk_key)) begin
        lk_match = 1'b1;
        lk_idx   = SPARE_SEL_W'(i);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LK_DONE       <= 1'b0;
      LK_HIT        <= 1'b0;
      LK_SPARE_SEL  <= '0;
      LK_SPARE_ADDR <= '0;
    end else begin
      LK_DONE <= LK_VALID;
      if (LK_VALID && lk_match && MAP_READY) begin
        LK_HIT        <= 1'b1;
        LK_SPARE_SEL  <= lk_idx;
        LK_SPARE_ADDR <= LK_ADDR[SPARE_ADDR_W-1:0];
      end else begin
        LK_HIT        <= 1'b0;
        LK_SPARE_SEL  <= '0;
        LK_SPARE_ADDR <= '0;
      end
    end
  end

endmodule

// File: tb/tb_repair_fault_map.sv
// Bench for repair_fault_map: directed scenarios plus randomized traffic against a queue-based map model.
module tb_repair_fault_map;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BIST_EN = 1'b0;
  logic        FAULT_VALID = 1'b0;
  logic [5:0]  FAULT_SEL = '0;
  logic [9:0]  FAULT_ADDR = '0;
  logic        LK_VALID = 1'b0;
  logic [15:0] LK_ADDR = '0;
  logic        LK_DONE;
  logic        LK_HIT;
  logic [4:0]  LK_SPARE_SEL;
  logic [6:0]  LK_SPARE_ADDR;
  logic [4:0]  FAULT_CNT;
  logic        OVERFLOW;
  logic        MAP_READY;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: list of stored segment keys in arrival order; position = spare bank.
  int m_keys[$];
  bit m_ovf;
  int m_phase; // 0 idle, 1 collecting, 2 sealed
  bit e_done, e_hit;
  int e_sel, e_addr;

  repair_fault_map dut (
    .CLK(CLK), .RST(RST), .BIST_EN(BIST_EN), .FAULT_VALID(FAULT_VALID),
    .FAULT_SEL(FAULT_SEL), .FAULT_ADDR(FAULT_ADDR), .LK_VALID(LK_VALID),
    .LK_ADDR(LK_ADDR), .LK_DONE(LK_DONE), .LK_HIT(LK_HIT),
    .LK_SPARE_SEL(LK_SPARE_SEL), .LK_SPARE_ADDR(LK_SPARE_ADDR),
    .FAULT_CNT(FAULT_CNT), .OVERFLOW(OVERFLOW), .MAP_READY(MAP_READY)
  );

  always #5 CLK = ~CLK;

  function automatic int find_key(input int k);
    foreach (m_keys[i]) if (m_keys[i] == k) return i;
    return -1;
  endfunction

  // Drive one cycle of inputs, advance the model, and return 1 ns after the edge.
  task automatic drive(input bit ben, input bit fv, input int fs, input int fa,
                       input bit lv, input int la);
    int idx;
    int fk;
    BIST_EN = ben; FAULT_VALID = fv; FAULT_SEL = 6'(fs); FAULT_ADDR = 10'(fa);
    LK_VALID = lv; LK_ADDR = 16'(la);
    idx    = find_key(la / 128);
    e_done = lv;
    e_hit  = lv && (m_phase == 2) && (idx >= 0);
    e_sel  = e_hit ? idx : 0;
    e_addr = e_hit ? (la % 128) : 0;
    if (m_phase != 1 && ben) begin
      m_keys.delete(); m_ovf = 0; m_phase = 1;
    end else if (m_phase == 1 && !ben) begin
      m_phase = 2;
    end else if (m_phase == 1 && fv) begin
      fk = fs * 8 + fa / 128;
      if (find_key(fk) < 0) begin
        if (m_keys.size() < 25) m_keys.push_back(fk);
        else m_ovf = 1;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; BIST_EN = 0; FAULT_VALID = 0; LK_VALID = 0; LK_ADDR = '0;
    m_keys.delete(); m_ovf = 0; m_phase = 0;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    n_cmp++;
    if ({LK_DONE, LK_HIT, LK_SPARE_SEL, LK_SPARE_ADDR, FAULT_CNT, OVERFLOW, MAP_READY} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got done=%b hit=%b sel=%0d addr=%0d cnt=%0d ovf=%b rdy=%b want all 0",
               LK_DONE, LK_HIT, LK_SPARE_SEL, LK_SPARE_ADDR, FAULT_CNT, OVERFLOW, MAP_READY);
    end
    do_reset();
    drive(0, 0, 0, 0, 1, 16'h0000);
    n_cmp++;
    if (LK_DONE !== 1'b1 || LK_HIT !== 1'b0 || FAULT_CNT !== 5'd0 || MAP_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lookup got done=%b hit=%b cnt=%0d rdy=%b want 1 0 0 0",
               LK_DONE, LK_HIT, FAULT_CNT, MAP_READY);
    end
  endtask

  task automatic test_single_repair();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 5, 10'h185, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 16'h1585);
    n_cmp++;
    if (LK_HIT !== 1'b1 || LK_SPARE_SEL !== 5'd0 || LK_SPARE_ADDR !== 7'h05 || MAP_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL single_repair got hit=%b sel=%0d addr=%h rdy=%b want 1 0 05 1",
               LK_HIT, LK_SPARE_SEL, LK_SPARE_ADDR, MAP_READY);
    end
  endtask

  task automatic test_segment_boundary();
    drive(0, 0, 0, 0, 1, 16'h1500);
    n_cmp++;
    if (LK_HIT !== 1'b0 || LK_DONE !== 1'b1) begin
      n_fail++;
      $display("FAIL seg_below got hit=%b done=%b want 0 1", LK_HIT, LK_DONE);
    end
    drive(0, 0, 0, 0, 1, 16'h15FF);
    n_cmp++;
    if (LK_HIT !== 1'b1 || LK_SPARE_ADDR !== 7'h7F) begin
      n_fail++;
      $display("FAIL seg_top got hit=%b addr=%h want 1 7f", LK_HIT, LK_SPARE_ADDR);
    end
  endtask

  task automatic test_duplicates();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 2, 10'h010, 0, 0);
    drive(1, 1, 2, 10'h011, 0, 0);
    drive(1, 1, 2, 10'h07F, 0, 0);
    drive(1, 1, 3, 10'h010, 0, 0);
    n_cmp++;
    if (FAULT_CNT !== 5'd2) begin
      n_fail++;
      $display("FAIL dup_count got %0d want 2", FAULT_CNT);
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 16'h0C10);
    n_cmp++;
    if (LK_HIT !== 1'b1 || LK_SPARE_SEL !== 5'd1 || LK_SPARE_ADDR !== 7'h10) begin
      n_fail++;
      $display("FAIL dup_lookup got hit=%b sel=%0d addr=%h want 1 1 10", LK_HIT, LK_SPARE_SEL, LK_SPARE_ADDR);
    end
  endtask

  task automatic test_overflow();
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 26; k++) drive(1, 1, k, 0, 0, 0);
    n_cmp++;
    if (FAULT_CNT !== 5'd25 || OVERFLOW !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_state got cnt=%0d ovf=%b want 25 1", FAULT_CNT, OVERFLOW);
    end
    // Lookup on the sealing edge sees CAPTURE state and must miss.
    drive(0, 0, 0, 0, 1, 16'h6000);
    n_cmp++;
    if (LK_HIT !== 1'b0 || MAP_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL seal_edge_lookup got hit=%b rdy=%b want 0 1", LK_HIT, MAP_READY);
    end
    drive(0, 0, 0, 0, 1, 16'h6400);
    n_cmp++;
    if (LK_HIT !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_key26 got hit=%b want 0", LK_HIT);
    end
    drive(0, 0, 0, 0, 1, 16'h6000);
    n_cmp++;
    if (LK_HIT !== 1'b1 || LK_SPARE_SEL !== 5'd24) begin
      n_fail++;
      $display("FAIL ovf_key25 got hit=%b sel=%0d want 1 24", LK_HIT, LK_SPARE_SEL);
    end
  endtask

  task automatic test_rerun_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(1, 1, 10 + k, 10'h200, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (FAULT_CNT !== 5'd3 || MAP_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL rerun_setup got cnt=%0d rdy=%b want 3 1", FAULT_CNT, MAP_READY);
    end
    // Fault on the rising BIST_EN edge is dropped; only the clear happens.
    drive(1, 1, 40, 0, 1, 16'h2A00);
    n_cmp++;
    if (FAULT_CNT !== 5'd0 || OVERFLOW !== 1'b0 || MAP_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL rerun_clear got cnt=%0d ovf=%b rdy=%b want 0 0 0", FAULT_CNT, OVERFLOW, MAP_READY);
    end
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 16'h2A00);
    n_cmp++;
    if (LK_HIT !== 1'b0 || LK_DONE !== 1'b1 || FAULT_CNT !== 5'd0) begin
      n_fail++;
      $display("FAIL rerun_old_key got hit=%b done=%b cnt=%0d want 0 1 0", LK_HIT, LK_DONE, FAULT_CNT);
    end
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 7, 10'h300, 1, 0);
    drive(1, 1, 8, 10'h300, 1, 0);
    RST = 1'b1;
    #2;
    n_cmp++;
    if ({LK_DONE, LK_HIT, LK_SPARE_SEL, LK_SPARE_ADDR, FAULT_CNT, OVERFLOW, MAP_READY} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got done=%b hit=%b cnt=%0d ovf=%b rdy=%b want all 0",
               LK_DONE, LK_HIT, FAULT_CNT, OVERFLOW, MAP_READY);
    end
    m_keys.delete(); m_ovf = 0; m_phase = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    // BIST_EN still high: the first edge out of reset enters CAPTURE with an empty table.
    drive(1, 1, 7, 10'h300, 0, 0);
    n_cmp++;
    if (FAULT_CNT !== 5'd0 || MAP_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_enter got cnt=%0d rdy=%b want 0 0", FAULT_CNT, MAP_READY);
    end
    drive(1, 1, 7, 10'h300, 0, 0);
    n_cmp++;
    if (FAULT_CNT !== 5'd1) begin
      n_fail++;
      $display("FAIL post_reset_capture got cnt=%0d want 1", FAULT_CNT);
    end
  endtask

  task automatic test_random();
    bit ben;
    int fs, fa, la, ki;
    do_reset();
    ben = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 3) ben = ~ben;
      fs = $urandom_range(0, 15);
      fa = $urandom_range(0, 1023);
      if (m_keys.size() > 0 && $urandom_range(0, 1) == 1) begin
        ki = m_keys[$urandom_range(0, m_keys.size() - 1)];
        la = ki * 128 + $urandom_range(0, 127);
      end else begin
        la = $urandom_range(0, 16'hFFFF) % (16 * 1024);
      end
      drive(ben, 1'($urandom_range(0, 1)), fs, fa, 1'($urandom_range(0, 1)), la);
      n_cmp++;
      if (LK_DONE !== e_done || LK_HIT !== e_hit || LK_SPARE_SEL !== 5'(e_sel) ||
          LK_SPARE_ADDR !== 7'(e_addr)) begin
        n_fail++;
        $display("FAIL rand_lookup cyc=%0d got done=%b hit=%b sel=%0d addr=%0d want %b %b %0d %0d",
                 c, LK_DONE, LK_HIT, LK_SPARE_SEL, LK_SPARE_ADDR, e_done, e_hit, e_sel, e_addr);
      end
      n_cmp++;
      if (FAULT_CNT !== 5'(m_keys.size()) || OVERFLOW !== m_ovf || MAP_READY !== (m_phase == 2)) begin
        n_fail++;
        $display("FAIL rand_state cyc=%0d got cnt=%0d ovf=%b rdy=%b want %0d %b %b",
                 c, FAULT_CNT, OVERFLOW, MAP_READY, m_keys.size(), m_ovf, m_phase == 2);
      end
    end
  endtask

  initial begin
    m_ovf = 0; m_phase = 0;
    test_reset();
    test_single_repair();
    test_segment_boundary();
    test_duplicates();
    test_overflow();
    test_rerun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
